// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor controller: FSM state and the
// in-flight tracking entry {table index, predicted direction}.
package bp_pkg;

  localparam int BP_BHT_ADDR_LEN = 7;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bp_state_t;

  typedef struct packed {
    logic [BP_BHT_ADDR_LEN-1:0] index;
    logic                       predicted;
  } bp_entry_t;

endpackage

// File: rtl/bp_track_fifo.sv
// Synchronous circular queue of in-flight predictions; clear wins over
// push/pop so a mispredict drops everything, including a same-cycle push.
module bp_track_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [W-1:0]           din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           head
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch history table sequencer: fetch-side lookup, in-flight tracking,
// update/flush on resolution. Optional counters under BP_STATS_EN.
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int BHT_ADDR_LEN = 7,
  parameter int QUEUE_DEPTH  = 4
`ifdef BP_STATS_EN
  , parameter int CNT_W      = 32
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         if_valid,
  input  logic [31:0]                  if_pc,
  output logic                         if_ready,
  output logic [BHT_ADDR_LEN-1:0]      bht_raddr,
  input  logic                         bht_taken,
  output logic                         pred_taken,
  input  logic                         ex_valid,
  input  logic                         ex_taken,
  output logic                         bht_we,
  output logic [BHT_ADDR_LEN-1:0]      bht_waddr,
  output logic                         bht_wtaken,
  output logic                         flush,
  output logic [$clog2(QUEUE_DEPTH):0] occupancy,
  output logic                         underflow_err
`ifdef BP_STATS_EN
  , output logic [CNT_W-1:0]           br_cnt
  , output logic [CNT_W-1:0]           miss_cnt
`endif
);
  localparam int EW = BHT_ADDR_LEN + 1;

  bp_state_t               state, next_state;
  logic                    full, empty;
  logic [EW-1:0]           head;
  logic [BHT_ADDR_LEN-1:0] head_index;
  logic                    head_pred;
  logic                    push, resolve, mispredict, underflow_hit;
  logic                    we_p1, wtaken_p1, flush_p1, underflow_p1;
  logic [BHT_ADDR_LEN-1:0] waddr_p1;
  logic                    unused_pc;

  assign unused_pc  = ^{if_pc[31:BHT_ADDR_LEN+2], if_pc[1:0]};
  assign bht_raddr  = if_pc[BHT_ADDR_LEN+1:2];
  assign pred_taken = if_valid & bht_taken;
  assign head_index = head[EW-1:1];
  assign head_pred  = head[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  always_comb begin
    next_state    = RUN;
    if_ready      = 1'b0;
    push          = 1'b0;
    resolve       = 1'b0;
    mispredict    = 1'b0;
    underflow_hit = 1'b0;
    case (state)
      RUN: begin
        if_ready      = ~full;
        push          = if_valid & ~full;
        resolve       = ex_valid & ~empty;
        underflow_hit = ex_valid & empty;
        mispredict    = resolve & (head_pred != ex_taken);
        if (mispredict) next_state = FLUSH;
      end
      default: next_state = RUN;
    endcase
  end

  bp_track_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .W     (EW)
  ) u_track (
    .clk   (clk),
    .rst   (rst),
    .push  (push & ~mispredict),
    .pop   (resolve & ~mispredict),
    .clear (mispredict),
    .din   ({bht_raddr, bht_taken}),
    .full  (full),
    .empty (empty),
    .count (occupancy),
    .head  (head)
  );

  // p0 -> p1: resolution outcome becomes the table write and flush pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_p1        <= 1'b0;
      waddr_p1     <= '0;
      wtaken_p1    <= 1'b0;
      flush_p1     <= 1'b0;
      underflow_p1 <= 1'b0;
    end else begin
      we_p1    <= resolve;
      flush_p1 <= mispredict;
      if (underflow_hit) underflow_p1 <= 1'b1;
      if (resolve) begin
        waddr_p1  <= head_index;
        wtaken_p1 <= ex_taken;
      end
    end
  end

  assign bht_we        = we_p1;
  assign bht_waddr     = waddr_p1;
  assign bht_wtaken    = wtaken_p1;
  assign flush         = flush_p1;
  assign underflow_err = underflow_p1;

`ifdef BP_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else begin
      if (resolve)    br_cnt   <= sat_inc(br_cnt);
      if (mispredict) miss_cnt <= sat_inc(miss_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl against a queue-based model.
module tb_branch_predict_ctrl;
  localparam int AW = 7;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0, bht_taken = 1'b0, ex_valid = 1'b0, ex_taken = 1'b0;
  logic [31:0] if_pc = '0;
  logic        if_ready, pred_taken, bht_we, bht_wtaken, flush, underflow_err;
  logic [AW-1:0] bht_raddr, bht_waddr;
  logic [2:0]  occupancy;
`ifdef BP_STATS_EN
  logic [31:0] br_cnt, miss_cnt;
`endif

  branch_predict_ctrl #(.BHT_ADDR_LEN(AW), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_ready(if_ready),
    .bht_raddr(bht_raddr), .bht_taken(bht_taken), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_taken(ex_taken), .bht_we(bht_we), .bht_waddr(bht_waddr),
    .bht_wtaken(bht_wtaken), .flush(flush), .occupancy(occupancy),
    .underflow_err(underflow_err)
`ifdef BP_STATS_EN
    , .br_cnt(br_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int idx; bit pred;} ent_t;
  ent_t    mq[$];
  bit      m_in_flush, m_under, e_we, e_wt, e_flush;
  int      e_waddr;
  longint  m_br, m_miss;
  int      compared = 0;
  int      mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_in_flush = 0; m_under = 0; e_we = 0; e_wt = 0; e_flush = 0; e_waddr = 0;
    m_br = 0; m_miss = 0;
  endtask

  task automatic check_regs();
    chk("bht_we", bht_we, e_we);
    chk("flush", flush, e_flush);
    chk("occupancy", occupancy, mq.size());
    chk("underflow_err", underflow_err, m_under);
    if (e_we) begin
      chk("bht_waddr", bht_waddr, e_waddr);
      chk("bht_wtaken", bht_wtaken, e_wt);
    end
`ifdef BP_STATS_EN
    chk("br_cnt", br_cnt, m_br);
    chk("miss_cnt", miss_cnt, m_miss);
`endif
  endtask

  // One clock: drive, check fetch path, advance model, check registered outputs
  task automatic cycle(input bit iv, input logic [31:0] pc, input bit bt,
                       input bit ev, input bit et);
    bit   ready, push;
    ent_t h;
    if_valid = iv; if_pc = pc; bht_taken = bt; ex_valid = ev; ex_taken = et;
    #1;
    ready = !m_in_flush && (mq.size() < QD);
    chk("if_ready", if_ready, ready);
    chk("bht_raddr", bht_raddr, int'(pc[8:2]));
    chk("pred_taken", pred_taken, iv & bt);
    push = iv && ready;
    e_we = 0; e_flush = 0;
    if (m_in_flush) begin
      m_in_flush = 0;
    end else begin
      if (ev && mq.size() == 0) m_under = 1;
      else if (ev) begin
        h = mq.pop_front();
        e_we = 1; e_waddr = h.idx; e_wt = et;
        if (m_br < 64'hFFFF_FFFF) m_br++;
        if (h.pred != et) begin
          mq.delete(); e_flush = 1; m_in_flush = 1; push = 0;
          if (m_miss < 64'hFFFF_FFFF) m_miss++;
        end
      end
      if (push) mq.push_back('{int'(pc[8:2]), bt});
    end
    @(posedge clk); #1;
    check_regs();
  endtask

  task automatic do_reset();
    if_valid = 0; bht_taken = 0; ex_valid = 0; ex_taken = 0; if_pc = '0;
    rst = 1'b1;
    #1;
    model_reset();
    check_regs();
    chk("rst_waddr", bht_waddr, 0);
    chk("rst_wtaken", bht_wtaken, 0);
    chk("rst_if_ready", if_ready, 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Single correct resolution
    cycle(1, 32'h100, 1, 0, 0);
    cycle(0, 32'h0, 0, 1, 1);
    chk("tp1_waddr", bht_waddr, 7'h40);

    // Mispredict flushes the queue; FLUSH cycle ignores fetch and EX
    cycle(1, 32'h100, 1, 0, 0);
    cycle(1, 32'h104, 0, 0, 0);
    cycle(1, 32'h108, 1, 1, 0);
    chk("tp2_flush", flush, 1);
    cycle(1, 32'h10c, 1, 1, 1);
    cycle(0, 32'h0, 0, 0, 0);

    // Fill the queue, refuse a fifth, reopen after one resolve
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 32'h400 + 32'(4 * i), i[0], 0, 0);
    chk("tp3_occ_full", occupancy, 4);
    cycle(0, 32'h0, 0, 1, mq[0].pred);
    cycle(1, 32'h500, 1, 0, 0);

    // Push with simultaneous correct resolve across pointer wrap
    do_reset();
    cycle(1, 32'h200, 1, 0, 0);
    cycle(1, 32'h204, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 32'h208 + 32'(4 * i), i[0], 1, mq[0].pred);

    // Underflow is sticky until reset
    do_reset();
    cycle(0, 32'h0, 0, 1, 0);
    cycle(1, 32'h600, 1, 0, 0);
    cycle(0, 32'h0, 0, 1, 1);
    chk("tp5_sticky", underflow_err, 1);
    do_reset();

`ifdef BP_STATS_EN
    for (int i = 0; i < 10; i++) begin
      cycle(1, 32'h300 + 32'(4 * i), i[0], 0, 0);
      cycle(0, 32'h0, 0, 1, (i < 3) ? !i[0] : i[0]);
      cycle(0, 32'h0, 0, 0, 0);
    end
    chk("stats_br", br_cnt, 10);
    chk("stats_miss", miss_cnt, 3);
    do_reset();
    chk("stats_br_rst", br_cnt, 0);
`endif

    // Randomized traffic with an asynchronous reset mid-stream
    for (int i = 0; i < 400; i++) begin
      bit ev, et;
      if (i == 200) do_reset();
      ev = ($urandom % 5) < 2;
      et = (mq.size() > 0 && ($urandom % 5) != 0) ? mq[0].pred : 1'($urandom % 2);
      cycle(1'($urandom % 2), $urandom, 1'($urandom % 2), ev, et);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Sequences the 2-bit branch history table for the pipeline. Drives the table's read index at fetch and captures its prediction. Tracks in-flight predictions in an ordered queue until the branch resolves in EX. On resolution it issues the single table update write and, on a misprediction, a flush/redirect pulse.

## Interface
- BHT_ADDR_LEN, 7, table index width; index = pc[BHT_ADDR_LEN+1:2]
- QUEUE_DEPTH, 4, in-flight tracking entries; power of two, ≥2
- CNT_W, 32, statistics counter width (only with BP_STATS_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_valid  in  1  fetch presents a branch instruction this cycle
- if_pc  in  32  PC of that instruction
- if_ready  out  1  controller can accept a fetch-side branch (comb.)
- bht_raddr  out  BHT_ADDR_LEN  table read index = if_pc[BHT_ADDR_LEN+1:2] (comb.)
- bht_taken  in  1  table prediction for bht_raddr (comb. from table)
- pred_taken  out  1  prediction forwarded to fetch = if_valid & bht_taken (comb.)
- ex_valid  in  1  oldest in-flight branch resolves this cycle
- ex_taken  in  1  actual outcome of that branch
- bht_we  out  1  table update strobe (registered)
- bht_waddr  out  BHT_ADDR_LEN  update index (registered)
- bht_wtaken  out  1  update direction (registered)
- flush  out  1  mispredict pulse to IF/ID (registered)
- occupancy  out  $clog2(QUEUE_DEPTH)+1  queued entries (registered)
- underflow_err  out  1  sticky: ex_valid seen with empty queue

## Operation
- Queue entry = {index, predicted}. Push when if_valid & if_ready; pop when ex_valid accepted.
- FSM states RUN, FLUSH. Reset → RUN.
- RUN: if_ready = ~full. Both push and pop may occur in one cycle. When full, no push, even if a pop happens that cycle.
- Resolve (RUN, ex_valid, queue non-empty):
  - Pop the head.
  - Next cycle: bht_we=1, bht_waddr=head.index, bht_wtaken=ex_taken.
  - If head.predicted ≠ ex_taken: also flush=1 next cycle. The whole queue is cleared, and any same-cycle push is discarded. Go to FLUSH.
- FLUSH: lasts exactly one cycle. if_ready=0; ex_valid ignored (no pop, no update, no error). Return to RUN.
- ex_valid with empty queue in RUN: no pop, no update. underflow_err set and held until rst.
- Occupancy arithmetic: next = cur + push − pop, or 0 on mispredict. Pointers wrap modulo QUEUE_DEPTH.

## Timing
- Fetch path is combinational: bht_raddr, pred_taken, if_ready in the same cycle as if_valid.
- Update/flush latency: exactly 1 cycle after the accepted ex_valid. Each is a single-cycle pulse per resolution.
- Back-to-back resolutions give back-to-back bht_we pulses. After a mispredict, the next resolution can be accepted no earlier than 2 cycles later.
- Reset values: bht_we=0, bht_waddr=0, bht_wtaken=0, flush=0, occupancy=0, underflow_err=0, state=RUN. if_ready is therefore 1.
- Mid-operation rst discards all queue contents and pending pulses immediately.

## Configuration
- BP_STATS_EN defined:
  - Adds outputs br_cnt and miss_cnt (CNT_W each, reset 0).
  - br_cnt increments per accepted resolution; miss_cnt increments per mispredict.
  - Both saturate at all-ones.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package bp_pkg holds:
  - state enum {RUN, FLUSH}
  - queue entry struct {index, predicted}, parameterised by BHT_ADDR_LEN via localparam default 7
- Sub-module bp_track_fifo holds:
  - synchronous circular queue: push, pop, clear, full, empty, count, head
  - clear has priority over push/pop
- FSM, update registers and stats live in the top module.

## Test plan
- Reset, push pc 0x100 with bht_taken=1, resolve ex_taken=1 → next cycle bht_we=1, bht_waddr=0x40, bht_wtaken=1, flush=0, occupancy 1→0.
- Push 0x100(pred 1), 0x104(pred 0); resolve head ex_taken=0 → flush=1, bht_wtaken=0, occupancy=0, FLUSH cycle if_ready=0.
- Four pushes with no resolve → occupancy=4, if_ready=0. Fifth if_valid is not queued. One resolve → if_ready=1 next cycle.
- Simultaneous push and correct resolve at occupancy 2 → occupancy stays 2, FIFO order preserved across pointer wrap (8 iterations).
- ex_valid with empty queue → no bht_we, underflow_err=1 until rst.
- BP_STATS_EN: 10 resolutions with 3 mispredicts → br_cnt=10, miss_cnt=3. Assert rst mid-stream → all zero.
